// File: rtl/mul_tree_pkg.sv
// Shared helpers for the parametrised multiplier tree: level geometry and output saturation.
// Used by mul_tree_level and mul_tree_pipe.
package mul_tree_pkg;

    // Widest intermediate the saturation helper can handle; FULL_W + 1 must stay below this.
    localparam int SAT_MAX_W = 256;

    typedef struct packed {
        logic [SAT_MAX_W-1:0] value;
        logic                 sat;
    } sat_result_t;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    function automatic int num_levels(input int num_ops);
        return clog2(num_ops);
    endfunction

    function automatic int level_width(input int in_w, input int level);
        return in_w << (level + 1);
    endfunction

    function automatic int level_pairs(input int num_ops, input int level);
        return num_ops >> (level + 1);
    endfunction

    // The value arrives sign- or zero-extended to SAT_MAX_W+1 bits; the result sits in the low width bits.
    function automatic sat_result_t saturate(input logic [SAT_MAX_W:0] value,
                                             input int                 width,
                                             input logic               is_signed);
        logic [SAT_MAX_W:0] ones;
        logic [SAT_MAX_W:0] max_v;
        logic [SAT_MAX_W:0] min_v;
        sat_result_t        r;
        ones    = '1;
        r.value = value[SAT_MAX_W-1:0];
        r.sat   = 1'b0;
        if (is_signed) begin
            max_v = ones >> (SAT_MAX_W + 2 - width);
            min_v = ~max_v;
            if ($signed(value) > $signed(max_v)) begin
                r.value = max_v[SAT_MAX_W-1:0];
                r.sat   = 1'b1;
            end else if ($signed(value) < $signed(min_v)) begin
                r.value = min_v[SAT_MAX_W-1:0];
                r.sat   = 1'b1;
            end
        end else begin
            max_v = ones >> (SAT_MAX_W + 1 - width);
            if (value > max_v) begin
                r.value = max_v[SAT_MAX_W-1:0];
                r.sat   = 1'b1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/mul_tree_level.sv
// One level of the multiplier tree: PAIRS adjacent W-bit operand pairs multiplied into 2W-bit
// products, followed by a multiply register and a retiming register, each with its valid bit.
module mul_tree_level
    import mul_tree_pkg::*;
#(
    parameter int PAIRS  = 2,
    parameter int W      = 10,
    parameter int SIGNED = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ce,
    input  logic                   in_valid,
    input  logic [2*PAIRS*W-1:0]   in_data,
    output logic                   out_valid,
    output logic [2*PAIRS*W-1:0]   out_data
);

    localparam int PW = 2 * W;

    logic [PAIRS*PW-1:0] prod;
    logic [PAIRS*PW-1:0] mul_q;
    logic                mul_v;

    // Operands are extended to the product width first; the low 2W bits of that product are exact
    // for both signed and unsigned operands, so one multiplier form serves both modes.
    for (genvar p = 0; p < PAIRS; p++) begin : g_pair
        logic [W-1:0]  op_a;
        logic [W-1:0]  op_b;
        logic [PW-1:0] a_ext;
        logic [PW-1:0] b_ext;

        assign op_a = in_data[(2*p)*W +: W];
        assign op_b = in_data[(2*p+1)*W +: W];

        if (SIGNED != 0) begin : g_sext
            assign a_ext = {{W{op_a[W-1]}}, op_a};
            assign b_ext = {{W{op_b[W-1]}}, op_b};
        end else begin : g_zext
            assign a_ext = {{W{1'b0}}, op_a};
            assign b_ext = {{W{1'b0}}, op_b};
        end

        assign prod[p*PW +: PW] = a_ext * b_ext;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mul_q     <= '0;
            mul_v     <= 1'b0;
            out_data  <= '0;
            out_valid <= 1'b0;
        end else if (ce) begin
            mul_q     <= prod;
            mul_v     <= in_valid;
            out_data  <= mul_q;
            out_valid <= mul_v;
        end
    end

endmodule

// File: rtl/mul_tree_pipe.sv
// Pipelined NUM_OPS-operand multiplier tree with scaling, optional rounding and saturation.
// Define MUL_TREE_ROUND_EN to round half up in the scale stage; otherwise the shift truncates.
module mul_tree_pipe
    import mul_tree_pkg::*;
#(
    parameter int NUM_OPS   = 4,
    parameter int IN_W      = 10,
    parameter int SIGNED    = 0,
    parameter int OUT_SHIFT = 0,
    parameter int OUT_W     = 40
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ce,
    input  logic                    in_valid,
    input  logic [NUM_OPS*IN_W-1:0] in_data,
    output logic                    out_valid,
    output logic [OUT_W-1:0]        out_data,
    output logic                    out_sat
);

    localparam int L       = num_levels(NUM_OPS);
    localparam int FULL_W  = NUM_OPS * IN_W;
    localparam int EXT_W   = FULL_W + 1;
    localparam int SAT_PAD = SAT_MAX_W + 1 - EXT_W;

`ifdef MUL_TREE_ROUND_EN
    // Half an output LSB; collapses to zero when OUT_SHIFT is 0.
    localparam logic [EXT_W-1:0] ROUND_ADD = (EXT_W'(1) << OUT_SHIFT) >> 1;
`endif

    logic [FULL_W-1:0]  tree_data  [0:L];
    logic               tree_valid [0:L];

    logic [EXT_W-1:0]   prod_ext;
    logic [EXT_W-1:0]   rounded;
    logic [EXT_W-1:0]   shifted;
    logic [SAT_MAX_W:0] sat_in;
    sat_result_t        sat_res;
    logic               sat_unused;

    assign tree_data[0]  = in_data;
    assign tree_valid[0] = in_valid;

    // Every level keeps the total width at FULL_W: half as many operands, each twice as wide.
    for (genvar j = 0; j < L; j++) begin : g_level
        mul_tree_level #(
            .PAIRS  (level_pairs(NUM_OPS, j)),
            .W      (IN_W << j),
            .SIGNED (SIGNED)
        ) u_level (
            .clk       (clk),
            .rst       (rst),
            .ce        (ce),
            .in_valid  (tree_valid[j]),
            .in_data   (tree_data[j]),
            .out_valid (tree_valid[j+1]),
            .out_data  (tree_data[j+1])
        );
    end

    // The extra top bit absorbs the rounding carry so it reaches the saturation check.
    always_comb begin
        prod_ext = (SIGNED != 0) ? {tree_data[L][FULL_W-1], tree_data[L]}
                                 : {1'b0, tree_data[L]};
`ifdef MUL_TREE_ROUND_EN
        rounded = prod_ext + ROUND_ADD;
`else
        rounded = prod_ext;
`endif
        if (SIGNED != 0) begin
            shifted = $unsigned($signed(rounded) >>> OUT_SHIFT);
        end else begin
            shifted = rounded >> OUT_SHIFT;
        end
        sat_in  = (SIGNED != 0) ? {{SAT_PAD{shifted[EXT_W-1]}}, shifted}
                                : {{SAT_PAD{1'b0}}, shifted};
        sat_res = saturate(sat_in, OUT_W, SIGNED != 0);
    end

    assign sat_unused = ^sat_res.value[SAT_MAX_W-1:OUT_W];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sat   <= 1'b0;
        end else if (ce) begin
            out_valid <= tree_valid[L];
            out_data  <= sat_res.value[OUT_W-1:0];
            out_sat   <= sat_res.sat;
        end
    end

endmodule
